reset_sequencer: RTL and testbench

- Parametrised power-on and push-button reset generator for boards with a PLL.
- Holds NUM_OUT active-low reset outputs low until the PLL reports lock, a settle time has elapsed, and the reset button is released (debounced).
- Then releases the outputs one at a time, in index order, at fixed intervals.
- Replaces the hard-tied reset_n driven from top-level PLL test designs; downstream consumers (e.g. the Z8S180 board reset, local logic) each get an ordered release.

---
 rtl/reset_sequencer_pkg.sv | 17 +
 rtl/reset_sequencer_debounce.sv | 50 +++++
 rtl/reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_reset_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and a sizing helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// Two-flop synchroniser plus debounce filter for an active-low push-button.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES consecutive differing samples per level change.
// Backpressure: none; free-running level filter.
//
// Ports:
//   clk, reset_n : clock and async active-low reset
//   raw_n        : raw, bouncing, asynchronous button level (0 = pressed)
//   level_n      : debounced level (0 = pressed), resets to released
module reset_sequencer_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_n,
  output logic level_n
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_n;
      sync_q  <= sync1_q;
      // Any sample agreeing with the accepted level restarts the run, so a
      // change is only taken after an unbroken run of differing samples.
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == TERM) begin
        level_q <= sync_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_n = level_q;

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / push-button reset generator: waits for PLL lock + settle, then releases outputs in index order.
// Latency: first output releases LOCK_CYCLES + STAGE_CYCLES edges after SETTLE entry; STAGE_CYCLES between bits.
// Backpressure: none; lock loss or button press aborts and re-asserts all outputs on the next edge.
//
// Ports:
//   clk, reset_n : clock and async active-low reset
//   pll_locked   : asynchronous PLL lock indication
//   button_n     : raw active-low reset push-button
//   rst_out_n    : sequenced active-low resets, bit k released after bit k-1
//   ready        : high once every rst_out_n bit is released
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_OUT         = 3,
  parameter int LOCK_CYCLES     = 1024,
  parameter int STAGE_CYCLES    = 256,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               button_n,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               ready
);

  localparam int CNT_W = $clog2(max_int(LOCK_CYCLES, STAGE_CYCLES)) + 1;
  localparam int STG_W = $clog2(NUM_OUT) + 1;

  localparam logic [CNT_W-1:0] LOCK_TERM  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_TERM = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(NUM_OUT - 1);

  logic lock_s1;
  logic lock_s;
  logic btn_db;
  logic seq_ok;

  seq_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic               ready_q, ready_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_s1 <= pll_locked;
      lock_s  <= lock_s1;
    end
  end

  reset_sequencer_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_n  (button_n),
    .level_n(btn_db)
  );

  // Sequencing may only proceed while locked and the button is released.
  assign seq_ok = lock_s & btn_db;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    ready_d = ready_q;

    if (state_q != WAIT_LOCK && !seq_ok) begin
      // Abort outranks every state transition; partially released outputs
      // drop back together.
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          rst_d   = '0;
          ready_d = 1'b0;
          if (seq_ok) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
        SETTLE: begin
          if (cnt_q == LOCK_TERM) begin
            state_d = RELEASE;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == STAGE_TERM) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (stage_q == STG_W'(i)) rst_d[i] = 1'b1;
            end
            cnt_d = '0;
            if (stage_q == LAST_STAGE) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          rst_d   = '1;
          ready_d = 1'b1;
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  assign rst_out_n = rst_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (3-output and degenerate 1-output) share stimulus.
// A behavioural model tracks "edges since the sequence started" and predicts every output cycle.
// Directed scenarios pin the model with literal timing, then randomized lock/button/reset traffic.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       button_n = 1'b1;
  logic [2:0] rst_a;
  logic       rdy_a;
  logic [0:0] rst_b;
  logic       rdy_b;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_OUT(3), .LOCK_CYCLES(4), .STAGE_CYCLES(3), .DEBOUNCE_CYCLES(4)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .button_n(button_n),
    .rst_out_n(rst_a), .ready(rdy_a)
  );

  reset_sequencer #(
    .NUM_OUT(1), .LOCK_CYCLES(4), .STAGE_CYCLES(1), .DEBOUNCE_CYCLES(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .button_n(button_n),
    .rst_out_n(rst_b), .ready(rdy_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  p_n[2] = '{3, 1};
  int  p_l[2] = '{4, 4};
  int  p_s[2] = '{3, 1};
  int  p_d[2] = '{4, 4};

  int  edge_n = 0;
  bit  m_lk1, m_lk, m_b1, m_b;
  bit  m_db[2];
  int  m_run[2];
  bit  m_active[2];
  int  m_e0[2];
  int  exp_mask[2];
  int  exp_rdy[2];

  task automatic model_reset();
    m_lk1 = 0; m_lk = 0; m_b1 = 1; m_b = 1;
    for (int i = 0; i < 2; i++) begin
      m_db[i] = 1; m_run[i] = 0; m_active[i] = 0; m_e0[i] = 0;
      exp_mask[i] = 0; exp_rdy[i] = 0;
    end
  endtask

  task automatic model_step();
    int pos, rel;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      // Decision uses the synchronised/debounced view as it stood before this edge.
      if (m_active[i]) begin
        if (!(m_lk && m_db[i])) m_active[i] = 0;
      end else if (m_lk && m_db[i]) begin
        m_active[i] = 1;
        m_e0[i] = edge_n;
      end
      // Accept a new button level after p_d consecutive differing samples.
      if (m_b != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == p_d[i]) begin
          m_db[i] = m_b;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_lk = m_lk1; m_lk1 = pll_locked;
    m_b = m_b1;   m_b1 = button_n;
    for (int i = 0; i < 2; i++) begin
      rel = 0;
      if (m_active[i]) begin
        pos = edge_n - m_e0[i];
        if (pos >= p_l[i] + p_s[i]) rel = (pos - p_l[i]) / p_s[i];
        if (rel > p_n[i]) rel = p_n[i];
      end
      exp_mask[i] = (1 << rel) - 1;
      exp_rdy[i]  = (rel == p_n[i]) ? 1 : 0;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("rst_a", 32'(rst_a), exp_mask[0]);
      check("rdy_a", 32'(rdy_a), exp_rdy[0]);
      check("rst_b", 32'(rst_b), exp_mask[1]);
      check("rdy_b", 32'(rdy_b), exp_rdy[1]);
      check("order_a", 32'(((rst_a >> 1) & ~rst_a) != 3'b000), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic edges(input int k);
    repeat (k) @(posedge clk);
    #3;
  endtask

  initial begin
    int r;
    edges(3);
    check("reset_rst_a", 32'(rst_a), 0);
    check("reset_rdy_a", 32'(rdy_a), 0);
    reset_n = 1'b1;
    edges(5);

    // Normal release: lock sampled at edge T (the next edge), SETTLE at T+2.
    pll_locked = 1'b1;
    edges(7);  check("b_pre", 32'(rst_b), 0);        // after T+6
    edges(1);  check("b_rel", 32'(rst_b), 1);        // T+7
               check("b_rdy", 32'(rdy_b), 1);
    edges(1);  check("a_t8", 32'(rst_a), 0);         // T+8
    edges(1);  check("a_t9", 32'(rst_a), 32'h1);     // T+9
    edges(3);  check("a_t12", 32'(rst_a), 32'h3);    // T+12
    edges(2);  check("a_t14_rdy", 32'(rdy_a), 0);    // T+14
    edges(1);  check("a_t15", 32'(rst_a), 32'h7);    // T+15
               check("a_t15_rdy", 32'(rdy_a), 1);

    // Lock lost in RUN, then in RELEASE with 011 out.
    pll_locked = 1'b0;
    edges(3);  check("run_lockloss", 32'(rst_a), 0);
    pll_locked = 1'b1;
    edges(13); check("relock_011", 32'(rst_a), 32'h3);
    pll_locked = 1'b0;
    edges(3);  check("rel_lockloss", 32'(rst_a), 0);
               check("rel_lockloss_rdy", 32'(rdy_a), 0);
    pll_locked = 1'b1;
    edges(16); check("relock_full", 32'(rst_a), 32'h7);

    // Button bounce in RUN: short presses ignored.
    for (int len = 1; len <= 3; len++) begin
      button_n = 1'b0;
      edges(len);
      button_n = 1'b1;
      edges(6);
      check("bounce_ignored", 32'(rdy_a), 1);
    end
    button_n = 1'b0;
    edges(8);  check("press_abort", 32'(rst_a), 0);
    button_n = 1'b1;
    edges(2);
    button_n = 1'b0;
    edges(6);  check("release_glitch", 32'(rst_a), 0);
    button_n = 1'b1;                                 // first sample at edge R
    edges(19); check("btn_replay_pre", 32'(rdy_a), 0); // R+18
    edges(1);  check("btn_replay", 32'(rst_a), 32'h7); // R+19

    // Async reset from RUN, lock held through reset: first release at
    // edge F+2+L+S where F is the first edge after deassertion.
    reset_n = 1'b0;
    #1;
    check("async_rst_a", 32'(rst_a), 0);
    check("async_rdy_a", 32'(rdy_a), 0);
    edges(2);
    reset_n = 1'b1;
    edges(9);  check("pwr_pre", 32'(rst_a), 0);      // F+8
    edges(1);  check("pwr_first", 32'(rst_a), 32'h1); // F+9
    edges(6);  check("pwr_full", 32'(rst_a), 32'h7);

    // Async reset mid-SETTLE, then the same timing from the next lock sample.
    pll_locked = 1'b0;
    edges(4);
    pll_locked = 1'b1;
    edges(5);
    reset_n = 1'b0;
    #1;
    check("settle_rst", 32'(rst_a), 0);
    edges(2);
    reset_n = 1'b1;
    edges(10); check("settle_rst_first", 32'(rst_a), 32'h1);
    edges(6);  check("settle_rst_full", 32'(rdy_a), 1);

    // Randomized lock / button / reset traffic checked by the model.
    for (int seg = 0; seg < 80; seg++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        pll_locked = ($urandom_range(0, 5) != 0);
        button_n   = ($urandom_range(0, 4) != 0);
        edges($urandom_range(1, 40));
      end else if (r <= 7) begin
        button_n = 1'b0;
        edges($urandom_range(1, 6));
        button_n = 1'b1;
        edges($urandom_range(1, 20));
      end else if (r == 8) begin
        pll_locked = ~pll_locked;
        edges($urandom_range(1, 3));
        pll_locked = ~pll_locked;
        edges($urandom_range(1, 20));
      end else begin
        reset_n = 1'b0;
        edges($urandom_range(1, 3));
        reset_n = 1'b1;
        edges($urandom_range(1, 20));
      end
    end

    edges(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
